fifo_flush_ctrl: RTL and testbench
==================================

// Module: fifo_flush_ctrl
// PURPOSE
// - Drain/flush sequencer for the nibble-in / 32-bit-out flushable FIFO. Tracks FIFO
//   fill in nibbles, pops only complete 32-bit words in normal mode, and runs the
//   flush handshake (explicit request or idle timeout) to extract the padded partial word.
// - Presents popped words on a registered valid/ready stream to the downstream consumer.
// PARAMETERS
// - DEPTH_NIB    32  FIFO capacity in nibbles (multiple of 8)
// - IDLE_TIMEOUT 16  idle cycles with a stranded partial word before auto-flush
// PORTS
// - clk               in  1   clock
// - reset             in  1   asynchronous, active-high
// - fifo_wr_valid_i   in  1   FIFO write strobe (monitored; one nibble written)
// - wr_stall_o        out 1   upstream must not write while 1
// - fifo_rd_valid_o   out 1   pop one word (combinational)
// - fifo_rd_data_i    in  32  FIFO read data for current word
// - fifo_flush_o      out 1   FIFO flush request (registered)
// - fifo_flush_done_i in  1   FIFO flush-done indication
// - fifo_full_i       in  1   FIFO full
// - flush_req_i       in  1   software flush request (sampled in IDLE only)
// - out_valid_o       out 1   output word valid
// - out_ready_i       in  1   consumer ready
// - out_data_o        out 32  output word
// - out_last_o        out 1   word is final word of a flush
// - flush_done_o      out 1   one-cycle pulse: flush complete
// - err_o             out 1   sticky protocol error
// BEHAVIOUR
// - Reset (reset, asynchronous, active-high; clock clk): state=IDLE, nib_cnt=0, idle_cnt=0,
//   all outputs 0.
// - nib_cnt (0..DEPTH_NIB): +1 per fifo_wr_valid_i; on pop -min(8,nib_cnt); both same cycle apply both.
// - slot_free = !out_valid_o || out_ready_i. Pop => out_data_o<=fifo_rd_data_i, out_valid_o<=1,
//   out_last_o<=(state==FLUSH && nib_cnt<=8). Handshake without pop => out_valid_o<=0.
// - out_data_o/out_last_o held stable while out_valid_o && !out_ready_i.
// - FSM:
//   IDLE : pop when nib_cnt>=8 && slot_free. Go ARM on flush_req_i or timeout hit.
//          Write in this cycle still accepted and counted.
//   ARM  : fifo_flush_o=1, wr_stall_o=1, no pop; exactly 1 cycle -> FLUSH.
//   FLUSH: fifo_flush_o=1, wr_stall_o=1; pop when nib_cnt>0 && slot_free.
//          nib_cnt==0 on entry -> DONE with no word output. Pop with nib_cnt<=8 -> DONE.
//   DONE : fifo_flush_o=0, wr_stall_o=1; when slot_free: flush_done_o=1 for that cycle -> IDLE.
// - fifo_flush_o low for >=1 cycle between flushes (DONE guarantees rising edge per flush).
// - Latency: pop cycle -> out_valid_o next cycle. Full-word stream sustains 1 word/cycle.
// - err_o set (sticky until reset): write while nib_cnt==DEPTH_NIB; write while wr_stall_o;
//   out_last pop with fifo_flush_done_i==0; fifo_full_i != (nib_cnt==DEPTH_NIB).
// - Reset mid-flush: immediate return to IDLE, no flush_done_o pulse.
// CONFIGURATION
// - FLUSH_IDLE_TIMEOUT_EN defined: idle_cnt clears on write, pop, or nib_cnt%8==0; else +1 in
//   IDLE; timeout hit when idle_cnt==IDLE_TIMEOUT -> ARM, idle_cnt cleared.
// - Not defined: idle_cnt absent; flush only via flush_req_i.
// TESTING
// - Write 16 nibbles 0..F, out_ready=1 -> two words 0x76543210, 0xFEDCBA98, out_last=0, nib_cnt=0.
// - Write 3 nibbles 1,2,3, flush_req pulse -> ARM,FLUSH; one word 0xCCCCC321 with out_last=1,
//   flush_done_o pulse, wr_stall_o high ARM..DONE only.
// - flush_req with nib_cnt=0 -> ARM,FLUSH,DONE; no out_valid, flush_done_o pulse, err_o=0.
// - out_ready=0 holding 2 full words -> out_data stable; no pop; release -> words in order, no loss.
// - FLUSH_IDLE_TIMEOUT_EN, 5 nibbles then idle -> auto flush after 16 idle cycles, word
//   0xCCC43210 (data 0..4), out_last=1.
// - Write 33rd nibble at DEPTH_NIB -> err_o=1 sticky; assert reset mid-FLUSH -> all outputs 0.

Source files
------------

// File: rtl/fifo_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flush_ctrl
// Description : Drain/flush sequencer for a nibble-in / 32-bit-out FIFO.
//               Pops full words in normal mode and runs the flush handshake
//               to extract the padded partial word onto a valid/ready stream.
//               Optional macro FLUSH_IDLE_TIMEOUT_EN adds an idle auto-flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flush_ctrl #(
  parameter int DEPTH_NIB    = 32,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fifo_wr_valid_i,
  output logic        wr_stall_o,
  output logic        fifo_rd_valid_o,
  input  logic [31:0] fifo_rd_data_i,
  output logic        fifo_flush_o,
  input  logic        fifo_flush_done_i,
  input  logic        fifo_full_i,
  input  logic        flush_req_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic        flush_done_o,
  output logic        err_o
);

  localparam int                 c_cnt_w = $clog2(DEPTH_NIB + 1);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH_NIB);
  localparam logic [c_cnt_w-1:0] c_word  = c_cnt_w'(8);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_zero  = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_nib_cnt;
  logic [c_cnt_w-1:0] w_pop_nib;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_slot_free;
  logic               w_pop;
  logic               w_last;
  logic               w_full_cnt;
  logic               w_wr_inc;
  logic               w_timeout;

  assign w_slot_free = !out_valid_o || out_ready_i;
  assign w_full_cnt  = (r_nib_cnt == c_depth);

  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_IDLE:  w_pop = (r_nib_cnt >= c_word) && w_slot_free;
      S_FLUSH: w_pop = (r_nib_cnt != c_zero) && w_slot_free;
      default: w_pop = 1'b0;
    endcase
  end

  assign fifo_rd_valid_o = w_pop;
  assign w_last          = (r_state == S_FLUSH) && (r_nib_cnt <= c_word);
  assign w_pop_nib       = (r_nib_cnt < c_word) ? r_nib_cnt : c_word;
  // A write at full is flagged as an error and never pushes the count past capacity.
  assign w_wr_inc        = fifo_wr_valid_i && !w_full_cnt;
  assign w_cnt_nxt       = r_nib_cnt - (w_pop ? w_pop_nib : c_zero) + (w_wr_inc ? c_one : c_zero);

`ifdef FLUSH_IDLE_TIMEOUT_EN
  localparam int c_idle_w = $clog2(IDLE_TIMEOUT + 1);

  logic [c_idle_w-1:0] r_idle_cnt;

  assign w_timeout = (r_state == S_IDLE) && (r_idle_cnt == c_idle_w'(IDLE_TIMEOUT));

  // Counts only while a partial word sits stranded with no traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt <= '0;
    end else if ((r_state != S_IDLE) || w_timeout || fifo_wr_valid_i || w_pop ||
                 (r_nib_cnt[2:0] == 3'd0)) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + c_idle_w'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_nib_cnt    <= '0;
      wr_stall_o   <= 1'b0;
      fifo_flush_o <= 1'b0;
      out_valid_o  <= 1'b0;
      out_data_o   <= '0;
      out_last_o   <= 1'b0;
      flush_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      r_nib_cnt    <= w_cnt_nxt;
      flush_done_o <= 1'b0;

      if (w_pop) begin
        out_data_o  <= fifo_rd_data_i;
        out_valid_o <= 1'b1;
        out_last_o  <= w_last;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end

      if ((fifo_wr_valid_i && (w_full_cnt || wr_stall_o)) ||
          (w_pop && w_last && !fifo_flush_done_i) ||
          (fifo_full_i != w_full_cnt)) begin
        err_o <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (flush_req_i || w_timeout) begin
            r_state      <= S_ARM;
            wr_stall_o   <= 1'b1;
            fifo_flush_o <= 1'b1;
          end
        end
        S_ARM: begin
          r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          // DONE drops the flush request so every flush sees a fresh rising edge.
          if ((r_nib_cnt == c_zero) || (w_pop && w_last)) begin
            r_state      <= S_DONE;
            fifo_flush_o <= 1'b0;
          end
        end
        S_DONE: begin
          if (w_slot_free) begin
            r_state      <= S_IDLE;
            wr_stall_o   <= 1'b0;
            flush_done_o <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_flush_ctrl
// Description : Bench for fifo_flush_ctrl with a behavioural nibble FIFO and
//               a stream-level word reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_flush_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_wr_valid_i = 1'b0;
  logic        wr_stall_o;
  logic        fifo_rd_valid_o;
  logic [31:0] fifo_rd_data_i;
  logic        fifo_flush_o;
  logic        fifo_flush_done_i;
  logic        fifo_full_i;
  logic        flush_req_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        flush_done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_flush_ctrl #(.DEPTH_NIB(32), .IDLE_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .fifo_wr_valid_i(fifo_wr_valid_i), .wr_stall_o(wr_stall_o),
    .fifo_rd_valid_o(fifo_rd_valid_o), .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_flush_o(fifo_flush_o), .fifo_flush_done_i(fifo_flush_done_i),
    .fifo_full_i(fifo_full_i), .flush_req_i(flush_req_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o),
    .flush_done_o(flush_done_o), .err_o(err_o)
  );

  // Behavioural nibble FIFO: pads missing nibbles of a partial word with 0xC.
  logic [3:0]  mem [0:63];
  int unsigned f_rp = 0, f_wp = 0, f_cnt = 0;
  int unsigned pop_n, push_n;
  logic        cap_wr = 1'b0, cap_rd = 1'b0;
  logic [3:0]  cap_nib = '0;
  logic [3:0]  wr_nib = '0;

  logic [32:0] obs_q[$];
  int          done_cnt = 0;
  int          stall_cnt = 0;

  always @(negedge clk) begin
    cap_wr  = fifo_wr_valid_i;
    cap_rd  = fifo_rd_valid_o;
    cap_nib = wr_nib;
    if (!reset) begin
      if (out_valid_o && out_ready_i) obs_q.push_back({out_last_o, out_data_o});
      if (flush_done_o) done_cnt++;
      if (wr_stall_o) stall_cnt++;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rp  <= 0;
      f_wp  <= 0;
      f_cnt <= 0;
    end else begin
      pop_n  = cap_rd ? ((f_cnt < 8) ? f_cnt : 8) : 0;
      push_n = (cap_wr && f_cnt < 32) ? 1 : 0;
      if (push_n != 0) mem[f_wp] <= cap_nib;
      f_wp  <= (f_wp + push_n) % 64;
      f_rp  <= (f_rp + pop_n) % 64;
      f_cnt <= f_cnt - pop_n + push_n;
    end
  end

  always_comb begin
    fifo_rd_data_i = '0;
    for (int i = 0; i < 8; i++)
      fifo_rd_data_i[i*4 +: 4] = (i < f_cnt) ? mem[(f_rp + i) % 64] : 4'hC;
  end

  assign fifo_full_i       = (f_cnt == 32);
  assign fifo_flush_done_i = fifo_flush_o;

  // Stream reference: nibbles group into words of 8; a flush emits the padded rest as last.
  logic [3:0]  ref_nibs[$];
  logic [32:0] exp_q[$];
  int          obs_rd = 0;
  int          exp_rd = 0;

  function automatic void ref_write(input logic [3:0] n);
    logic [31:0] w;
    ref_nibs.push_back(n);
    if (ref_nibs.size() == 8) begin
      for (int i = 0; i < 8; i++) w[i*4 +: 4] = ref_nibs[i];
      exp_q.push_back({1'b0, w});
      ref_nibs.delete();
    end
  endfunction

  function automatic void ref_flush();
    logic [31:0] w;
    if (ref_nibs.size() > 0) begin
      w = 32'hCCCC_CCCC;
      for (int i = 0; i < ref_nibs.size(); i++) w[i*4 +: 4] = ref_nibs[i];
      exp_q.push_back({1'b1, w});
      ref_nibs.delete();
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_nib(input logic [3:0] n);
    fifo_wr_valid_i = 1'b1;
    wr_nib          = n;
    tick();
    fifo_wr_valid_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_req_i = 1'b1;
    tick();
    flush_req_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done_cnt > d0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (obs_q.size() >= obs_rd + n) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({wr_stall_o, fifo_rd_valid_o, fifo_flush_o, out_valid_o, out_last_o, flush_done_o, err_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000", {wr_stall_o, fifo_rd_valid_o, fifo_flush_o,
               out_valid_o, out_last_o, flush_done_o, err_o});
    end
    checks++;
    if (out_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h required 00000000", out_data_o);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_words();
    bit ok;
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) write_nib(4'(i));
    wait_obs(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_words_count: got %0d words required 2", obs_q.size() - obs_rd);
    end else begin
      checks++;
      if (obs_q[obs_rd] !== {1'b0, 32'h76543210}) begin
        errors++;
        $display("FAIL full_word0: got %h required 076543210", obs_q[obs_rd]);
      end
      checks++;
      if (obs_q[obs_rd+1] !== {1'b0, 32'hFEDCBA98}) begin
        errors++;
        $display("FAIL full_word1: got %h required 0FEDCBA98", obs_q[obs_rd+1]);
      end
    end
    obs_rd = obs_q.size();
    tick();
    checks++;
    if ({err_o, wr_stall_o, out_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL full_words_idle: got err/stall/valid %b required 000", {err_o, wr_stall_o, out_valid_o});
    end
  endtask

  task automatic test_flush_partial();
    bit ok;
    int d0 = done_cnt;
    int s0 = stall_cnt;
    out_ready_i = 1'b1;
    write_nib(4'h1);
    write_nib(4'h2);
    write_nib(4'h3);
    pulse_flush();
    wait_done(d0, ok);
    tick();
    tick();
    checks++;
    if (!ok || obs_q.size() != obs_rd + 1) begin
      errors++;
      $display("FAIL partial_flush_words: got %0d words, done %0d, required 1 word", obs_q.size() - obs_rd, ok);
    end else begin
      checks++;
      if (obs_q[obs_rd] !== {1'b1, 32'hCCCCC321}) begin
        errors++;
        $display("FAIL partial_flush_word: got %h required 1CCCCC321", obs_q[obs_rd]);
      end
    end
    obs_rd = obs_q.size();
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL partial_flush_done: got %0d pulses required 1", done_cnt - d0);
    end
    checks++;
    if (stall_cnt - s0 != 3 || wr_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL partial_flush_stall: got %0d stall cycles required 3", stall_cnt - s0);
    end
  endtask

  task automatic test_empty_flush();
    bit ok;
    int d0 = done_cnt;
    int s0 = stall_cnt;
    int o0 = obs_q.size();
    out_ready_i = 1'b1;
    pulse_flush();
    wait_done(d0, ok);
    tick();
    checks++;
    if (!ok || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL empty_flush_done: got %0d pulses required 1", done_cnt - d0);
    end
    checks++;
    if (obs_q.size() != o0 || out_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL empty_flush_words: got %0d words required 0", obs_q.size() - o0);
    end
    checks++;
    if (stall_cnt - s0 != 3 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL empty_flush_stall_err: got stall %0d err %b required 3 0", stall_cnt - s0, err_o);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [3:0]  vals[16];
    logic [31:0] w;
    logic [31:0] held;
    out_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vals[i] = 4'($urandom_range(0, 15));
      write_nib(vals[i]);
    end
    tick();
    tick();
    held = out_data_o;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== held || fifo_rd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got valid %b data %h pop %b required 1 %h 0", out_valid_o, out_data_o,
               fifo_rd_valid_o, held);
    end
    out_ready_i = 1'b1;
    wait_obs(2, ok);
    tick();
    checks++;
    if (!ok || obs_q.size() != obs_rd + 2) begin
      errors++;
      $display("FAIL bp_count: got %0d words required 2", obs_q.size() - obs_rd);
    end else begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 8; i++) w[i*4 +: 4] = vals[k*8 + i];
        checks++;
        if (obs_q[obs_rd+k] !== {1'b0, w}) begin
          errors++;
          $display("FAIL bp_word%0d: got %h required %h", k, obs_q[obs_rd+k], {1'b0, w});
        end
      end
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_timeout();
    bit ok;
    int d0 = done_cnt;
    int n = 0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) write_nib(4'(i));
`ifdef FLUSH_IDLE_TIMEOUT_EN
    while (!out_valid_o && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n < 16 || n > 24) begin
      errors++;
      $display("FAIL timeout_latency: got %0d idle cycles required 16..24", n);
    end
`else
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (obs_q.size() != obs_rd || wr_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL no_autoflush: got %0d words stall %b required 0 0", obs_q.size() - obs_rd, wr_stall_o);
    end
    pulse_flush();
`endif
    wait_done(d0, ok);
    tick();
    checks++;
    if (!ok || obs_q.size() != obs_rd + 1) begin
      errors++;
      $display("FAIL timeout_words: got %0d words required 1", obs_q.size() - obs_rd);
    end else begin
      checks++;
      if (obs_q[obs_rd] !== {1'b1, 32'hCCC43210}) begin
        errors++;
        $display("FAIL timeout_word: got %h required 1CCC43210", obs_q[obs_rd]);
      end
    end
    obs_rd = obs_q.size();
  endtask

  task automatic test_random();
    bit ok;
    int d0;
    for (int r = 0; r < 3; r++) begin
      exp_q.delete();
      exp_rd = 0;
      obs_rd = obs_q.size();
      for (int c = 0; c < 40; c++) begin
        out_ready_i = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) != 0 && f_cnt < 32) begin
          fifo_wr_valid_i = 1'b1;
          wr_nib          = 4'($urandom_range(0, 15));
          ref_write(wr_nib);
        end else begin
          fifo_wr_valid_i = 1'b0;
        end
        tick();
      end
      fifo_wr_valid_i = 1'b0;
      for (int k = 0; k < 200 && f_cnt >= 8; k++) begin
        out_ready_i = ($urandom_range(0, 3) != 0);
        tick();
      end
      d0 = done_cnt;
      pulse_flush();
      ref_flush();
      for (int k = 0; k < 200 && done_cnt == d0; k++) begin
        out_ready_i = ($urandom_range(0, 3) != 0);
        tick();
      end
      out_ready_i = 1'b1;
      wait_obs(exp_q.size(), ok);
      tick();
      checks++;
      if (!ok || done_cnt != d0 + 1 || obs_q.size() - obs_rd != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d words %0d done required %0d words 1 done", r,
                 obs_q.size() - obs_rd, done_cnt - d0, exp_q.size());
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          checks++;
          if (obs_q[obs_rd+k] !== exp_q[k]) begin
            errors++;
            $display("FAIL rand%0d_word%0d: got %h required %h", r, k, obs_q[obs_rd+k], exp_q[k]);
          end
        end
      end
      obs_rd = obs_q.size();
      checks++;
      if (err_o !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_err: got %b required 0", r, err_o);
      end
    end
  endtask

  task automatic test_overflow_reset();
    int d0;
    out_ready_i = 1'b0;
    for (int i = 0; i < 40; i++) write_nib(4'(i));
    checks++;
    if (err_o !== 1'b0 || fifo_full_i !== 1'b1) begin
      errors++;
      $display("FAIL fill_no_err: got err %b full %b required 0 1", err_o, fifo_full_i);
    end
    write_nib(4'hA);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err: got %b required 1", err_o);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b required 1", err_o);
    end
    d0 = done_cnt;
    pulse_flush();
    tick();
    tick();
    checks++;
    if ({wr_stall_o, fifo_flush_o, out_valid_o} !== 3'b111) begin
      errors++;
      $display("FAIL mid_flush: got stall/flush/valid %b required 111", {wr_stall_o, fifo_flush_o, out_valid_o});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({wr_stall_o, fifo_rd_valid_o, fifo_flush_o, out_valid_o, out_last_o, flush_done_o, err_o,
         out_data_o} !== 39'b0) begin
      errors++;
      $display("FAIL async_reset: got ctrl %b data %h required all 0", {wr_stall_o, fifo_rd_valid_o,
               fifo_flush_o, out_valid_o, out_last_o, flush_done_o, err_o}, out_data_o);
    end
    tick();
    reset = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (done_cnt != d0 || err_o !== 1'b0 || wr_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got done %0d err %b stall %b required 0 0 0", done_cnt - d0, err_o, wr_stall_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_words();
    test_flush_partial();
    test_empty_flush();
    test_backpressure();
    test_timeout();
    test_random();
    test_overflow_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
